// File: rtl/datamem_pkg.sv
// datamem_pkg: shared types and constants for datamem_param.
// Contents: state_t FSM encoding, read-latency limits, and the stored word width.
// Macro DATAMEM_PARITY_EN widens each stored word by one even-parity bit.
package datamem_pkg;
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    function automatic int word_w(input int data_w);
`ifdef DATAMEM_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction
endpackage

// File: rtl/datamem_if.sv
// datamem_if: request/response bus between the load/store unit and datamem_param.
// Request: req_valid, req_ready, req_write, req_addr, req_wdata.
// Response: rsp_valid, rsp_rdata, plus rsp_parity_err when DATAMEM_PARITY_EN is defined.
// Modports: master (core side) and slave (memory side).
interface datamem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
`ifdef DATAMEM_PARITY_EN
    logic              rsp_parity_err;
    modport master (output req_valid, req_write, req_addr, req_wdata,
                    input req_ready, rsp_valid, rsp_rdata, rsp_parity_err);
    modport slave (input req_valid, req_write, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_parity_err);
`else
    modport master (output req_valid, req_write, req_addr, req_wdata,
                    input req_ready, rsp_valid, rsp_rdata);
    modport slave (input req_valid, req_write, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/datamem_array.sv
// datamem_array: raw single-port storage, synchronous write and registered read, no reset.
// Ports: clk; we/re write/read enables; addr word index; wdata store word; rdata last read word
// (holds while re is low).
module datamem_array #(
    parameter int W     = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/datamem_param.sv
// datamem_param: parametrised data memory behind a valid/ready request port.
// Ports: clk; rst_n async active-low reset; bus (datamem_if.slave) request/response;
// init_done high once the post-reset clear has finished.
// Optional: DATAMEM_PARITY_EN stores an even-parity bit per word and drives bus.rsp_parity_err.
module datamem_param
    import datamem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    datamem_if.slave bus,
    output logic     init_done
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int WW = word_w(DATA_W);

    state_t            state, state_nx;
    logic [AW-1:0]     clr_cnt;
    logic              run, accept, in_range;
    logic              arr_we, arr_re;
    logic [AW-1:0]     arr_addr;
    logic [WW-1:0]     arr_wdata, arr_rdata, req_word;
    logic              v1, oor1, rsp_v;
    logic [WW-1:0]     d1, d_out;
    logic [DATA_W-1:0] d_last;

    // Gating with rst_n keeps ready/done low during reset even when reset lands in S_RUN.
    assign run       = rst_n && state == S_RUN;
    assign init_done = run;
    assign accept    = bus.req_valid && run;
    assign in_range  = 32'(bus.req_addr) < DEPTH;

`ifdef DATAMEM_PARITY_EN
    assign req_word = {^bus.req_wdata, bus.req_wdata};
    // Bit DATA_W of d1 carries the parity error: total parity of the stored word is odd.
    assign d1 = oor1 ? '0 : {^arr_rdata, arr_rdata[DATA_W-1:0]};
    assign bus.rsp_parity_err = rsp_v && d_out[DATA_W];
`else
    assign req_word = bus.req_wdata;
    assign d1 = oor1 ? '0 : arr_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= state_t'(INIT_CLEAR != 0 ? S_CLEAR : S_RUN);
            clr_cnt <= '0;
            v1      <= 1'b0;
            oor1    <= 1'b0;
            d_last  <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= state == S_CLEAR ? clr_cnt + AW'(1) : '0;
            v1      <= accept && !bus.req_write;
            oor1    <= !in_range;
            if (rsp_v) d_last <= d_out[DATA_W-1:0];
        end
    end

    always_comb begin
        state_nx  = state;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = bus.req_addr[AW-1:0];
        arr_wdata = req_word;
        if (state == S_CLEAR) begin
            arr_we    = 1'b1;
            arr_addr  = clr_cnt;
            arr_wdata = '0;
            if (clr_cnt == AW'(DEPTH - 1)) state_nx = S_RUN;
        end else if (accept && in_range) begin
            arr_we = bus.req_write;
            arr_re = !bus.req_write;
        end
    end

    datamem_array #(.W(WW), .DEPTH(DEPTH), .AW(AW)) u_arr (
        .clk  (clk),
        .we   (arr_we),
        .re   (arr_re),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
        logic          v2;
        logic [WW-1:0] d2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign rsp_v = v2;
        assign d_out = d2;
    end else begin : g_lat1
        assign rsp_v = v1;
        assign d_out = d1;
    end

    assign bus.req_ready = run;
    assign bus.rsp_valid = rsp_v;
    // Outside response cycles the last delivered word is replayed.
    assign bus.rsp_rdata = rsp_v ? d_out[DATA_W-1:0] : d_last;
endmodule

// File: tb/tb_datamem_param.sv
// tb_datamem_param: directed self-checking bench for datamem_param.
// u0: DEPTH=16, RD_LAT=1, INIT_CLEAR=1.  u1: DEPTH=200, RD_LAT=2, INIT_CLEAR=0.
module tb_datamem_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b1;
    logic rst1_n = 1'b1;
    logic done0, done1;
    int checks = 0;
    int errors = 0;

    datamem_if #(.DATA_W(8), .ADDR_W(8)) b0 ();
    datamem_if #(.DATA_W(8), .ADDR_W(8)) b1 ();

    datamem_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RD_LAT(1), .INIT_CLEAR(1)) u0 (
        .clk(clk), .rst_n(rst0_n), .bus(b0), .init_done(done0));
    datamem_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .INIT_CLEAR(0)) u1 (
        .clk(clk), .rst_n(rst1_n), .bus(b1), .init_done(done1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic w, input logic [7:0] a, input logic [7:0] d);
        b0.req_valid = 1'b1; b0.req_write = w; b0.req_addr = a; b0.req_wdata = d;
        tick(1);
    endtask

    task automatic req1(input logic w, input logic [7:0] a, input logic [7:0] d);
        b1.req_valid = 1'b1; b1.req_write = w; b1.req_addr = a; b1.req_wdata = d;
        tick(1);
    endtask

    task automatic idle0;
        b0.req_valid = 1'b0;
        tick(1);
    endtask

    task automatic idle1;
        b1.req_valid = 1'b0;
        tick(1);
    endtask

    task automatic rsp(input string tag, input logic gv, input logic [7:0] gd,
                       input logic ev, input logic [7:0] ed);
        check({tag, "_valid"}, gv, ev);
        check({tag, "_data"}, gd, ed);
    endtask

    task automatic wait_clear0(input string tag);
        int n = 0;
        while (!b0.req_ready && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, n, 16);
        check({tag, "_done"}, done0, 1);
    endtask

    initial begin
        b0.req_valid = 0; b0.req_write = 0; b0.req_addr = 0; b0.req_wdata = 0;
        b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_wdata = 0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        tick(2);
        check("rst0_ready", b0.req_ready, 0);
        check("rst0_done", done0, 0);
        rsp("rst0", b0.rsp_valid, b0.rsp_rdata, 0, 8'h00);
        check("rst1_ready", b1.req_ready, 0);
        check("rst1_done", done1, 0);
        rsp("rst1", b1.rsp_valid, b1.rsp_rdata, 0, 8'h00);

        // u0: clear sequence, then basic store/load at latency 1
        rst0_n = 1'b1;
        wait_clear0("clr_cycles");
        req0(1, 3, 8'hA5);
        check("store_no_rsp", b0.rsp_valid, 0);
        req0(0, 3, 0);
        rsp("raw", b0.rsp_valid, b0.rsp_rdata, 1, 8'hA5);
        idle0;
        rsp("raw_hold", b0.rsp_valid, b0.rsp_rdata, 0, 8'hA5);
        for (int i = 0; i < 4; i++) req0(1, 8'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            req0(0, 8'(i), 0);
            rsp($sformatf("pipe0_%0d", i), b0.rsp_valid, b0.rsp_rdata, 1, 8'(8'h10 + i));
        end
        idle0;
        rsp("pipe0_end", b0.rsp_valid, b0.rsp_rdata, 0, 8'h13);

        // u0 range boundaries: 250 and 16 alias onto in-range indices if not dropped
        req0(1, 15, 8'h3C);
        req0(1, 10, 8'h5C);
        req0(1, 250, 8'hFF);
        req0(1, 16, 8'hEE);
        req0(0, 15, 0);
        rsp("last_addr", b0.rsp_valid, b0.rsp_rdata, 1, 8'h3C);
        req0(0, 250, 0);
        rsp("oor_load", b0.rsp_valid, b0.rsp_rdata, 1, 8'h00);
        req0(0, 10, 0);
        rsp("oor_no_alias10", b0.rsp_valid, b0.rsp_rdata, 1, 8'h5C);
        req0(0, 0, 0);
        rsp("oor_no_alias0", b0.rsp_valid, b0.rsp_rdata, 1, 8'h10);
        idle0;

`ifdef DATAMEM_PARITY_EN
        req0(1, 5, 8'h07);
        req0(1, 6, 8'h07);
        b0.req_valid = 1'b0;
        u0.u_arr.mem[5][0] = ~u0.u_arr.mem[5][0];
        check("par_idle", b0.rsp_parity_err, 0);
        req0(0, 5, 0);
        rsp("par_flip", b0.rsp_valid, b0.rsp_rdata, 1, 8'h06);
        check("par_flip_err", b0.rsp_parity_err, 1);
        req0(0, 6, 0);
        rsp("par_clean", b0.rsp_valid, b0.rsp_rdata, 1, 8'h07);
        check("par_clean_err", b0.rsp_parity_err, 0);
        req0(0, 250, 0);
        check("par_oor_err", b0.rsp_parity_err, 0);
        idle0;
        check("par_after_err", b0.rsp_parity_err, 0);
`endif

        // u0: reset wipes outputs, clear restarts and zeroes every word
        rst0_n = 1'b0;
        #1;
        rsp("rst0_again", b0.rsp_valid, b0.rsp_rdata, 0, 8'h00);
        check("rst0_again_ready", b0.req_ready, 0);
        tick(1);
        rst0_n = 1'b1;
        wait_clear0("reclr_cycles");
        for (int i = 0; i < 16; i++) begin
            req0(0, 8'(i), 0);
            rsp($sformatf("cleared_%0d", i), b0.rsp_valid, b0.rsp_rdata, 1, 8'h00);
        end
        idle0;

        // u1: no clear, latency 2
        rst1_n = 1'b1;
        tick(1);
        check("u1_ready", b1.req_ready, 1);
        check("u1_done", done1, 1);
        req1(1, 3, 8'hA5);
        req1(0, 3, 0);
        check("lat2_gap", b1.rsp_valid, 0);
        idle1;
        rsp("lat2_raw", b1.rsp_valid, b1.rsp_rdata, 1, 8'hA5);
        idle1;
        rsp("lat2_hold", b1.rsp_valid, b1.rsp_rdata, 0, 8'hA5);

        req1(1, 199, 8'h3C);
        req1(1, 250, 8'hFF);
        req1(0, 250, 0);
        req1(0, 199, 0);
        rsp("u1_oor", b1.rsp_valid, b1.rsp_rdata, 1, 8'h00);
        idle1;
        rsp("u1_199", b1.rsp_valid, b1.rsp_rdata, 1, 8'h3C);
        idle1;
        check("u1_199_end", b1.rsp_valid, 0);

        for (int i = 0; i < 4; i++) req1(1, 8'(10 + i), 8'(8'h10 + i));
        req1(0, 10, 0);
        check("pipe1_first_gap", b1.rsp_valid, 0);
        for (int i = 1; i < 4; i++) begin
            req1(0, 8'(10 + i), 0);
            rsp($sformatf("pipe1_%0d", i - 1), b1.rsp_valid, b1.rsp_rdata, 1, 8'(8'h10 + i - 1));
        end
        idle1;
        rsp("pipe1_3", b1.rsp_valid, b1.rsp_rdata, 1, 8'h13);
        idle1;
        rsp("pipe1_end", b1.rsp_valid, b1.rsp_rdata, 0, 8'h13);

        // u1: reset with a load in flight
        req1(0, 3, 0);
        b1.req_valid = 1'b0;
        rst1_n = 1'b0;
        #1;
        rsp("flush_rst", b1.rsp_valid, b1.rsp_rdata, 0, 8'h00);
        check("flush_rst_ready", b1.req_ready, 0);
        check("flush_rst_done", done1, 0);
        tick(1);
        check("flush_rst_edge", b1.rsp_valid, 0);
        rst1_n = 1'b1;
        tick(1);
        check("flush_after1", b1.rsp_valid, 0);
        tick(1);
        check("flush_after2", b1.rsp_valid, 0);
        req1(0, 3, 0);
        idle1;
        rsp("survive", b1.rsp_valid, b1.rsp_rdata, 1, 8'hA5);
        idle1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
- Parametrised successor to the 8-bit single-port data memory.
- Generic DATA_W/ADDR_W/DEPTH storage behind a valid/ready request port.
- Configurable read latency (1 or 2 cycles), explicit read-response valid, and a post-reset clear sequencer.
- Sits between the core's load/store unit and on-chip data storage; the core stalls on req_ready.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from accept edge to rsp_valid; legal values 1 or 2.
- INIT_CLEAR, 1, 1 = zero the whole array after every reset; 0 = contents survive reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  rsp_rdata valid this cycle (loads only).
- rsp_rdata  out  DATA_W  load data.
- init_done  out  1  clear sequence finished; mirrors state==S_RUN.
- rsp_parity_err  out  1  present only with DATAMEM_PARITY_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to S_CLEAR if INIT_CLEAR=1, else S_RUN.
  - Clear counter = 0; read pipeline flushed.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, rsp_parity_err=0.
  - The storage array itself is never reset.
- FSM S_CLEAR:
  - Writes 0 to address clr_cnt each cycle and increments clr_cnt.
  - When clr_cnt==DEPTH-1 is written, moves to S_RUN on the next edge.
  - The clear takes exactly DEPTH cycles after rst_n deasserts.
  - req_ready=0 throughout.
- FSM S_RUN:
  - req_ready=1 in every cycle.
  - A request is accepted on an edge where req_valid && req_ready.
- Store:
  - On the accept edge, dm[req_addr] <= req_wdata.
  - No response is generated.
- Load:
  - dm[req_addr] is sampled on the accept edge.
  - rsp_valid is high for exactly one cycle, RD_LAT cycles after the accept edge.
  - RD_LAT=1: valid in the cycle following the accept edge.
  - RD_LAT=2: one additional output register stage.
- Throughput:
  - One request per cycle, loads fully pipelined.
  - Back-to-back loads give back-to-back rsp_valid pulses, in order.
- Read-after-write:
  - A load accepted the cycle after a store to the same address returns the new data.
  - A single port means there is never a simultaneous read and write.
- Out of range (req_addr ≥ DEPTH):
  - Store is dropped.
  - Load still responds at normal latency with rsp_rdata=0.
- Output hold: rsp_rdata holds its last value while rsp_valid=0.
- Reset mid-operation:
  - In-flight loads are discarded; no rsp_valid is produced for them.
  - A clear in progress restarts from address 0.
- There is no backpressure on the response path; the consumer must always accept rsp_valid.

Optional Feature:
- Macro: DATAMEM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit, ^req_wdata, written on the store.
  - Clear writes data 0 with parity 0.
  - On a load, rsp_parity_err = (^data) != stored parity, aligned with rsp_valid and 0 otherwise.
  - Out-of-range loads report 0.
- Without the macro:
  - Array width is DATA_W.
  - Port rsp_parity_err does not exist.

Decomposition:
- Package datamem_pkg:
  - State enum {S_CLEAR, S_RUN}.
  - Constants RD_LAT_MIN=1 and RD_LAT_MAX=2.
  - A function computing the stored word width (DATA_W, or DATA_W+1 with parity).
- Sub-module datamem_array:
  - Raw storage with synchronous write and synchronous registered read, width/depth parametrised, no reset.
  - The top level keeps the FSM, clear counter, range check and latency pipeline.

Test Plan:
- Clear after reset: DEPTH=16, INIT_CLEAR=1, release rst_n → req_ready=0 for 16 cycles, then init_done=1; load of every address returns 0.
- Store then load: store 0xA5 to addr 3, load addr 3 next cycle → RD_LAT=1 gives rsp_valid one cycle later with 0xA5; RD_LAT=2 gives it two cycles later.
- Pipelined loads: preload addr 0..3 = 0x10..0x13, issue 4 back-to-back loads → 4 consecutive rsp_valid cycles with 0x10,0x11,0x12,0x13 in order.
- Out of range: DEPTH=200, store 0xFF to addr 250, then load 250 → rsp_valid with rsp_rdata=0; addr 199 is unaffected.
- Reset mid-operation: issue a load with RD_LAT=2, assert rst_n low one cycle later → no rsp_valid, and all outputs read 0 while in reset. With INIT_CLEAR=0, prior data survives (addr 3 still 0xA5).
- Parity (DATAMEM_PARITY_EN): store 0x07, backdoor-flip data bit 0, then load → rsp_parity_err=1 with rsp_valid; an unflipped word gives 0.
